// File: rtl/key_wave_sel.sv
// Debounced four-key front-panel selector driving the DDS wave_select input.
// Each accepted press toggles a registered one-hot selection; re-pressing the active key idles it.
module key_wave_sel #(
    parameter int unsigned CNT_MAX = 999_999,
    parameter int unsigned KEY_W   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] wave_select,
    output logic             key_flag
);

    localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {StIdle, StPress, StHeld, StRelease} key_state_e;

    logic [KEY_W-1:0] sync_q;
    logic [KEY_W-1:0] key_s_q;
    logic [KEY_W-1:0] press;

    // Idle level of the buttons is high, so the synchroniser resets to all ones.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q  <= '1;
            key_s_q <= '1;
        end else begin
            sync_q  <= key_in;
            key_s_q <= sync_q;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        key_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_k;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StIdle: begin
                    if (!key_s_q[i]) begin
                        state_d = StPress;
                        cnt_d   = '0;
                    end
                end
                StPress: begin
                    if (key_s_q[i]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StHeld: begin
                    if (key_s_q[i]) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                    end
                end
                StRelease: begin
                    if (!key_s_q[i]) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            press_k = (state_q == StPress) && !key_s_q[i] && (cnt_q == CntMax);
        end

        assign press[i] = press_k;
    end

    logic [KEY_W-1:0] sel_d;
    logic             flag_d;

    // Lowest-index press wins; the others are consumed without effect.
    always_comb begin
        sel_d  = wave_select;
        flag_d = 1'b0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (press[i] && !flag_d) begin
                flag_d = 1'b1;
                sel_d  = wave_select[i] ? '0 : (KEY_W'(1) << i);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wave_select <= '0;
            key_flag    <= 1'b0;
        end else begin
            wave_select <= sel_d;
            key_flag    <= flag_d;
        end
    end

endmodule

// File: tb/tb_key_wave_sel.sv
// Scoreboard bench for key_wave_sel: each driven press queues its expected selection and
// arrival cycle; a negedge monitor pops and compares on every key_flag pulse.
module tb_key_wave_sel;

    localparam int unsigned CNT_MAX = 9;
    localparam int unsigned KEY_W   = 4;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] wave_select;
    logic             key_flag;

    key_wave_sel #(
        .CNT_MAX(CNT_MAX),
        .KEY_W  (KEY_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .wave_select(wave_select),
        .key_flag   (key_flag)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [KEY_W-1:0] sel;
        int               cyc;
    } exp_t;

    exp_t             exp_q[$];
    logic [KEY_W-1:0] model_sel;
    logic [KEY_W-1:0] prev_sel = '0;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after a falling edge, well clear of the sampling edge.
    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    // Called in the same step a clean fall of key i is driven.
    task automatic expect_press(input int i);
        exp_t e;
        model_sel = model_sel[i] ? '0 : (4'b0001 << i);
        e.sel     = model_sel;
        e.cyc     = cyc + int'(CNT_MAX) + 4;
        exp_q.push_back(e);
    endtask

    task automatic press_release(input int i, input int hold);
        key_in = ~(4'b0001 << i);
        expect_press(i);
        wait_clk(hold);
        key_in = '1;
        wait_clk(20);
    endtask

    always @(negedge sys_clk) begin : monitor
        exp_t e;
        if (!sys_rst) begin
            if (key_flag) begin
                if (exp_q.size() == 0) begin
                    check("spurious_flag", key_flag, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sel", wave_select, e.sel);
                    check("latency", cyc, e.cyc);
                    check("onehot0", $onehot0(wave_select), 1);
                end
            end else if (wave_select !== prev_sel) begin
                check("stray_change", wave_select, prev_sel);
            end
        end
        prev_sel <= wave_select;
    end

    initial begin
        sys_rst   = 1'b1;
        key_in    = 4'b0000;
        model_sel = '0;

        // 1: reset held with all keys low, then released with keys high
        wait_clk(2);
        for (int k = 0; k < 4; k++) begin
            check("rst_sel", wave_select, 0);
            check("rst_flag", key_flag, 0);
            wait_clk(1);
        end
        key_in = 4'b1111;
        wait_clk(2);
        sys_rst = 1'b0;
        wait_clk(15);
        check("rst_rel_sel", wave_select, 0);
        check("rst_rel_flag", key_flag, 0);

        // 2: clean press of key1, one cycle before the expected edge still idle
        key_in = 4'b1101;
        expect_press(1);
        wait_clk(int'(CNT_MAX) + 3);
        check("t2_early", wave_select, 0);
        wait_clk(40 - int'(CNT_MAX) - 3);
        key_in = 4'b1111;
        wait_clk(20);
        check("t2_sel", wave_select, 4'b0010);

        // 3: bouncing key0 is rejected, then a solid press is accepted
        for (int k = 0; k < 4; k++) begin
            key_in = 4'b1110;
            wait_clk(5);
            key_in = 4'b1111;
            wait_clk(3);
        end
        wait_clk(20);
        check("t3_bounce", wave_select, 4'b0010);
        press_release(0, 30);
        check("t3_sel", wave_select, 4'b0001);

        // 4: toggle key2 on and off, then select key3
        press_release(2, 20);
        check("t4_on", wave_select, 4'b0100);
        press_release(2, 20);
        check("t4_off", wave_select, 4'b0000);
        press_release(3, 20);
        check("t4_k3", wave_select, 4'b1000);

        // 5: key0 and key3 fall together; key0 wins
        key_in = 4'b0110;
        expect_press(0);
        wait_clk(20);
        key_in = 4'b1111;
        wait_clk(20);
        check("t5_simul", wave_select, 4'b0001);
        press_release(3, 20);
        check("t5_k3", wave_select, 4'b1000);

        // 6: reset at cnt=5 of a key2 debounce; full window needed afterwards
        key_in = 4'b1011;
        wait_clk(8);
        sys_rst   = 1'b1;
        model_sel = '0;
        wait_clk(1);
        check("t6_rst_sel", wave_select, 0);
        check("t6_rst_flag", key_flag, 0);
        wait_clk(1);
        check("t6_rst_sel2", wave_select, 0);
        sys_rst = 1'b0;
        expect_press(2);
        wait_clk(int'(CNT_MAX) + 3);
        check("t6_rewindow", wave_select, 0);
        wait_clk(20);
        check("t6_sel", wave_select, 4'b0100);
        key_in = 4'b1111;
        wait_clk(20);
        check("t6_release", wave_select, 4'b0100);

        check("pending", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
